// File: rtl/execute_muldiv_pkg.sv
// RV32M multiply/divide shared definitions: funct3 op codes and FSM state type.
// No ports; imported by the multiply/divide top and its divider datapath.
// Op codes follow the RISC-V M-extension funct3 encoding.
package utils_top;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_t;

endpackage

// File: rtl/execute_muldiv_div.sv
// Iterative restoring radix-2 divider on unsigned magnitudes, one quotient bit per step.
// Ports: start_i loads dividend_i/divisor_i; step_i advances one bit; quot_o/rem_o give
// the quotient/remainder as they stand after the step currently being applied (combinational).
module execute_muldiv_div
    import utils_top::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            step_i,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o
);

    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q,  rem_d;
    logic [XLEN-1:0] dvs_q,  dvs_d;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // The quotient register doubles as the dividend shift register: its MSB
    // feeds the partial remainder while the new quotient bit enters at the LSB.
    // rem_q < dvs_q always holds, so bit XLEN of diff is a clean borrow flag.
    always_comb begin
        shifted = {rem_q, quot_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (diff[XLEN]) begin
            quot_o = {quot_q[XLEN-2:0], 1'b0};
            rem_o  = shifted[XLEN-1:0];
        end else begin
            quot_o = {quot_q[XLEN-2:0], 1'b1};
            rem_o  = diff[XLEN-1:0];
        end
    end

    always_comb begin
        quot_d = quot_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        if (start_i) begin
            quot_d = dividend_i;
            rem_d  = '0;
            dvs_d  = divisor_i;
        end else if (step_i) begin
            quot_d = quot_o;
            rem_d  = rem_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quot_q <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

endmodule

// File: rtl/execute_muldiv.sv
// Multi-cycle RV32M multiply/divide unit, one op in flight, valid/ready on both sides.
// Ports: clk/rst (sync, active-high), flush, in_valid/in_ready/funct3/a/b request side,
// out_valid/out_ready/y result side. Optional macro EXECUTE_MULDIV_FAST_MUL_EN: one-cycle multiply.
module execute_muldiv
    import utils_top::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] y
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   ma_q, ma_d;          // multiplicand magnitude
    logic [2*XLEN-1:0] prod_q, prod_d;      // {partial product, multiplier magnitude}
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   y_q, y_d;
    logic              out_valid_q, out_valid_d;

    logic              accept;
    logic              a_sgn, b_sgn, sa, sb;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_by_zero, div_ovf, special;
    logic [XLEN-1:0]   special_y;
    logic [2*XLEN-1:0] prod_step, prod_fix;
    logic [XLEN-1:0]   mul_y, div_y;
    logic [XLEN-1:0]   div_quot, div_rem;
    logic              busy_last;

    assign in_ready  = (state_q == MD_IDLE);
    assign out_valid = out_valid_q;
    assign y         = y_q;

    // flush outranks a new request, so a redirected op is never accepted.
    assign accept = in_valid & in_ready & ~flush;

    always_comb begin
        a_sgn = (funct3 == MD_MULH) || (funct3 == MD_MULHSU) ||
                (funct3 == MD_DIV)  || (funct3 == MD_REM);
        b_sgn = (funct3 == MD_MULH) || (funct3 == MD_DIV) || (funct3 == MD_REM);
        sa    = a_sgn & a[XLEN-1];
        sb    = b_sgn & b[XLEN-1];
        a_mag = sa ? (~a + 1'b1) : a;
        b_mag = sb ? (~b + 1'b1) : b;

        div_by_zero = funct3[2] && (b == '0);
        div_ovf     = ((funct3 == MD_DIV) || (funct3 == MD_REM)) &&
                      (a == MIN_INT) && (b == '1);
        special     = div_by_zero | div_ovf;

        // funct3[1] distinguishes REM/REMU from DIV/DIVU.
        if (div_by_zero) begin
            special_y = funct3[1] ? a : '1;
        end else begin
            special_y = funct3[1] ? '0 : MIN_INT;
        end
    end

`ifdef EXECUTE_MULDIV_FAST_MUL_EN
    assign prod_step = {{XLEN{1'b0}}, ma_q} * {{XLEN{1'b0}}, prod_q[XLEN-1:0]};
    assign busy_last = ~f3_q[2] | (cnt_q == CW'(XLEN-1));
`else
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole product right by one.
    logic [XLEN:0] mul_sum;
    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                       (prod_q[0] ? {1'b0, ma_q} : {(XLEN+1){1'b0}});
    assign prod_step = {mul_sum, prod_q[XLEN-1:1]};
    assign busy_last = (cnt_q == CW'(XLEN-1));
`endif

    // Results are formed from the values the final step produces so they land
    // in y_q on the same edge the FSM enters DONE.
    always_comb begin
        prod_fix = neg_q ? (~prod_step + 1'b1) : prod_step;
        mul_y    = (f3_q == MD_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        if (f3_q[1]) begin
            div_y = neg_q ? (~div_rem + 1'b1) : div_rem;
        end else begin
            div_y = neg_q ? (~div_quot + 1'b1) : div_quot;
        end
    end

    execute_muldiv_div #(
        .XLEN(XLEN)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (accept),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .step_i     ((state_q == MD_BUSY) & f3_q[2]),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ma_d        = ma_q;
        prod_d      = prod_q;
        f3_d        = f3_q;
        neg_d       = neg_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;

        case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    cnt_d  = '0;
                    ma_d   = a_mag;
                    prod_d = {{XLEN{1'b0}}, b_mag};
                    f3_d   = funct3;
                    // Remainder takes the dividend's sign; everything else the product of signs.
                    neg_d  = (funct3[2] & funct3[1]) ? sa : (sa ^ sb);
                    if (special) begin
                        state_d     = MD_DONE;
                        y_d         = special_y;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = MD_BUSY;
                    end
                end
            end
            MD_BUSY: begin
                prod_d = prod_step;
                if (busy_last) begin
                    state_d     = MD_DONE;
                    y_d         = f3_q[2] ? div_y : mul_y;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MD_DONE: begin
                if (out_ready) begin
                    state_d     = MD_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = MD_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        if (flush) begin
            state_d     = MD_IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MD_IDLE;
            cnt_q       <= '0;
            ma_q        <= '0;
            prod_q      <= '0;
            f3_q        <= MD_MUL;
            neg_q       <= 1'b0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ma_q        <= ma_d;
            prod_q      <= prod_d;
            f3_q        <= f3_d;
            neg_q       <= neg_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_execute_muldiv.sv
// Self-checking bench for execute_muldiv (XLEN=32) against an arithmetic reference model.
// Drives directed M-extension ops, flush/reset interruptions and result backpressure.
// Honors EXECUTE_MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_execute_muldiv;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_y = '0;
    bit          pend  = 0;

    execute_muldiv #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: plain 64-bit arithmetic with the M-extension corner rules.
    function automatic logic [31:0] model_y(input logic [2:0] f3, input logic [31:0] aa,
                                            input logic [31:0] bb);
        longint      sa, sb, ua, ub, p;
        logic [63:0] pu;
        bit          ovf;
        sa  = longint'($signed(aa));
        sb  = longint'($signed(bb));
        ua  = longint'({32'b0, aa});
        ub  = longint'({32'b0, bb});
        ovf = (aa == 32'h8000_0000) && (bb == 32'hFFFF_FFFF);
        p   = 0;
        pu  = '0;
        case (f3)
            3'd0: begin pu = {32'b0, aa} * {32'b0, bb}; return pu[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = {32'b0, aa} * {32'b0, bb}; return pu[63:32]; end
            3'd4: begin
                if (bb == 0) return 32'hFFFF_FFFF;
                if (ovf) return aa;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (bb == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (bb == 0) return aa;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (bb == 0) return aa;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] aa,
                                     input logic [31:0] bb);
        if (f3[2]) begin
            if (bb == 0) return 1;
            if ((f3 == 3'd4 || f3 == 3'd6) && aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF)
                return 1;
            return 33;
        end
`ifdef EXECUTE_MULDIV_FAST_MUL_EN
        return 2;
`else
        return 33;
`endif
    endfunction

    // Compare process: whenever a result is presented it must match the model
    // and the unit must refuse new work; a result with nothing pending is spurious.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!pend) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("y_vs_model", y, exp_y);
                check("in_ready_while_valid", 32'(in_ready), 32'd0);
            end
        end
    end

    task automatic do_op(input logic [2:0] f3, input logic [31:0] aa, input logic [31:0] bb,
                         input bit use_lit, input logic [31:0] lit, input int bp);
        int          lat;
        int          elat;
        logic [31:0] m;
        m    = model_y(f3, aa, bb);
        elat = model_lat(f3, aa, bb);
        if (use_lit) check("model_pin", m, lit);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        exp_y    = m;
        pend     = 1;
        funct3   = f3;
        a        = aa;
        b        = bb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(elat));
        if (out_valid) begin
            repeat (bp) begin
                @(posedge clk);
                #1;
                check("bp_valid_held", 32'(out_valid), 32'd1);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check("in_ready_after_take", 32'(in_ready), 32'd1);
            check("valid_drop_after_take", 32'(out_valid), 32'd0);
        end
        pend = 0;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        funct3    = 3'd0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_y", y, 32'd0);
        rst = 1'b0;

        // Directed vectors with hand-computed results.
        do_op(3'd0, 32'd7,          32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 0);
        do_op(3'd1, 32'h8000_0000,  32'h8000_0000, 1, 32'h4000_0000, 0);
        do_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 0);
        do_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0);
        do_op(3'd1, 32'hFFFF_FFFF,  32'd1,         1, 32'hFFFF_FFFF, 0);
        do_op(3'd4, 32'hFFFF_FFF9,  32'd2,         1, 32'hFFFF_FFFD, 0);
        do_op(3'd6, 32'hFFFF_FFF9,  32'd2,         1, 32'hFFFF_FFFF, 0);
        do_op(3'd5, 32'd100,        32'd7,         1, 32'd14,        0);
        do_op(3'd7, 32'd100,        32'd7,         1, 32'd2,         0);
        do_op(3'd4, 32'd7,          32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 0);
        do_op(3'd6, 32'd7,          32'hFFFF_FFFE, 1, 32'd1,         0);
        do_op(3'd5, 32'hFFFF_FFFF,  32'd1,         1, 32'hFFFF_FFFF, 0);
        do_op(3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 1, 32'd0,         0);
        do_op(3'd7, 32'h8000_0000,  32'hFFFF_FFFF, 1, 32'h8000_0000, 0);
        // Special cases: one-cycle latency.
        do_op(3'd4, 32'd5,          32'd0,         1, 32'hFFFF_FFFF, 0);
        do_op(3'd6, 32'd5,          32'd0,         1, 32'd5,         0);
        do_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 1, 32'h8000_0000, 0);
        do_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 1, 32'd0,         0);
        // Backpressure on both a long op and a special case.
        do_op(3'd0, 32'd7,          32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 5);
        do_op(3'd7, 32'd9,          32'd0,         1, 32'd9,         5);

        // Model-only checks on random operands, one per funct3.
        for (int i = 0; i < 8; i++) begin
            do_op(3'(i), $urandom, $urandom, 0, 32'd0, i % 3);
        end

        // Flush ten cycles into a DIV: no result, idle next cycle.
        @(negedge clk);
        funct3 = 3'd4; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("flush_busy_in_ready", 32'(in_ready), 32'd0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        repeat (40) @(posedge clk);
        do_op(3'd5, 32'd9, 32'd3, 1, 32'd3, 0);

        // Flush together with a request in IDLE: request dropped.
        @(negedge clk);
        funct3 = 3'd0; a = 32'd3; b = 32'd4; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_req_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("flush_req_still_idle", 32'(in_ready), 32'd1);
        repeat (40) @(posedge clk);

        // Reset while BUSY: outputs go back to reset values, no result.
        @(negedge clk);
        funct3 = 3'd7; a = 32'd50; b = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy_y", y, 32'd0);
        repeat (40) @(posedge clk);
        do_op(3'd0, 32'd6, 32'd7, 1, 32'd42, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
